control_jugador: RTL

CONTROL_JUGADOR -- requirements
Module: control_jugador

---
 rtl/juego_pkg.sv | 19 +
 rtl/sincronizador.sv | 21 ++
 rtl/control_jugador.sv | 121 ++++++++++++
 3 files changed

// File: rtl/juego_pkg.sv
// Shared game constants: road geometry, frame-tick line and the player FSM state type.
package juego_pkg;

  typedef enum logic [1:0] {
    QUIETO    = 2'd0,
    IZQUIERDA = 2'd1,
    DERECHA   = 2'd2
  } estado_t;

  localparam int unsigned ANCHO_COCHE = 100;
  localparam int unsigned BORDE_IZQ   = 100;
  localparam int unsigned BORDE_DER   = 540;
  localparam int unsigned X_MIN       = BORDE_IZQ;
  localparam int unsigned X_MAX       = BORDE_DER - ANCHO_COCHE;
  localparam int unsigned X_INIT      = 280;
  localparam int unsigned LINEA_TICK  = 480;
  localparam int unsigned VMAX_DEF    = 8;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for an asynchronous, active-high button.
module sincronizador (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[0], d};
    end
  end

  assign q = ff[1];

endmodule

// File: rtl/control_jugador.sv
// Player car horizontal control: per-frame FSM moving the car with saturation at the road edges.
// Optional macro ACELERACION_EN: speed ramps by 1 per frame up to VMAX instead of constant VMAX.
module control_jugador #(
  parameter int unsigned X_INIT = juego_pkg::X_INIT,
  parameter int unsigned X_MIN  = juego_pkg::X_MIN,
  parameter int unsigned X_MAX  = juego_pkg::X_MAX,
  parameter int unsigned VMAX   = juego_pkg::VMAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic [9:0] pixelX,
  input  logic [9:0] pixelY,
  output logic [9:0] posicionJugador,
  output logic       moviendo,
  output logic       borde
);

  import juego_pkg::estado_t;
  import juego_pkg::QUIETO;
  import juego_pkg::IZQUIERDA;
  import juego_pkg::DERECHA;

  localparam logic [3:0]  V_MAX    = 4'(VMAX);
  localparam logic [10:0] LIM_MIN  = 11'(X_MIN);
  localparam logic [10:0] LIM_MAX  = 11'(X_MAX);
  localparam logic [9:0]  POS_INIT = 10'(X_INIT);
  localparam logic [9:0]  LINEA    = 10'(juego_pkg::LINEA_TICK);

  logic izqS, derS;

  sincronizador u_syncIzq (.clk(clk), .rst_n(rst_n), .d(btn_izq), .q(izqS));
  sincronizador u_syncDer (.clk(clk), .rst_n(rst_n), .d(btn_der), .q(derS));

  // Tick fires only on the rising edge of the line-480/column-0 condition.
  logic condTick, condPrev, tick;
  assign condTick = (pixelY == LINEA) && (pixelX == 10'd0);
  assign tick     = condTick && !condPrev;

  estado_t     estado, estadoSig;
  logic [3:0]  v, vSig;
  logic [9:0]  posSig;
  logic        bordeSig;
  logic [10:0] ext, suma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      condPrev        <= 1'b0;
      estado          <= QUIETO;
      v               <= '0;
      posicionJugador <= POS_INIT;
      moviendo        <= 1'b0;
      borde           <= 1'b0;
    end else begin
      condPrev        <= condTick;
      estado          <= estadoSig;
      v               <= vSig;
      posicionJugador <= posSig;
      moviendo        <= (estadoSig != QUIETO);
      borde           <= bordeSig;
    end
  end

  always_comb begin
    estadoSig = estado;
    vSig      = v;
    posSig    = posicionJugador;
    bordeSig  = 1'b0;
    ext       = {1'b0, posicionJugador};
    suma      = ext;

    if (tick) begin
      unique case ({izqS, derS})
        2'b10:   estadoSig = IZQUIERDA;
        2'b01:   estadoSig = DERECHA;
        default: estadoSig = QUIETO;
      endcase

      if (estadoSig == QUIETO) begin
        vSig = '0;
      end else begin
`ifdef ACELERACION_EN
        if (estadoSig != estado) begin
          vSig = 4'd1;
        end else if (v < V_MAX) begin
          vSig = v + 4'd1;
        end else begin
          vSig = V_MAX;
        end
`else
        vSig = V_MAX;
`endif
      end

      // The move uses the speed just computed, so entry from rest moves immediately.
      unique case (estadoSig)
        IZQUIERDA: begin
          suma = ext - {7'b0, vSig};
          if (suma[10] || (suma < LIM_MIN)) begin
            posSig   = LIM_MIN[9:0];
            bordeSig = 1'b1;
          end else begin
            posSig = suma[9:0];
          end
        end
        DERECHA: begin
          suma = ext + {7'b0, vSig};
          if (suma > LIM_MAX) begin
            posSig   = LIM_MAX[9:0];
            bordeSig = 1'b1;
          end else begin
            posSig = suma[9:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
